fetch_stage: RTL

//  IF stage of the MIPS pipeline: owns the PC, issues instruction-memory requests and holds the IF/ID register.
//  The IF/ID register drives id_opcode/id_funct straight into the ID-stage control unit.

---
 rtl/mips_pipe_pkg.sv | 36 +++
 rtl/fetch_skid_buf.sv | 52 +++++
 rtl/fetch_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared constants for the MIPS pipeline fetch path. Provides
//               the stall/NOP macros, the bubble word, the halt sentinel word
//               (used when FETCH_HALT_EN is defined) and the fetch FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef STALL_OPCODE
`define STALL_OPCODE 6'b111111
`endif

`ifndef NOP_INST
`define NOP_INST 32'h0000_0000
`endif

package mips_pipe_pkg;

    // Word loaded into IF/ID for an empty (flushed or starved) slot
    localparam logic [31:0] BUBBLE_WORD = {`STALL_OPCODE, 26'b0};

    // Sentinel instruction that stops fetch when FETCH_HALT_EN is defined
    localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_SKID  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry buffer holding an instruction word and its PC+4
//               while the IF/ID register is stalled. Clear has priority over
//               load; drain empties the entry as it moves into IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_clear,
    input  logic [31:0]       i_data,
    input  logic [ADDR_W-1:0] i_pc4,
    output logic              o_valid,
    output logic [31:0]       o_data,
    output logic [ADDR_W-1:0] o_pc4
);

    logic              r_valid;
    logic [31:0]       r_data;
    logic [ADDR_W-1:0] r_pc4;

    // Entry bookkeeping: clear beats load, load beats drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc4   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc4   <= i_pc4;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc4   = r_pc4;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : MIPS IF stage. Owns the PC, issues one outstanding
//               instruction-memory request at a time, parks a returned word
//               in a skid buffer while ID stalls, applies branch/jump
//               redirects and drives the IF/ID register.
//               Optional feature macro: FETCH_HALT_EN (halt on 32'hFFFF_FFFF).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic              halted
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req_valid;
    logic              r_discard;
    logic              r_id_valid;
    logic [31:0]       r_id_instr;
    logic [ADDR_W-1:0] r_id_pc4;

    logic              w_hs;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_rdir_pc;
    logic              w_resp_live;
    logic              w_halt_word;
    logic              w_halted;
    logic              w_skid_load;
    logic              w_skid_drain;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [31:0]       w_skid_data;
    logic [ADDR_W-1:0] w_skid_pc4;

    assign w_hs        = r_req_valid & imem_req_ready;
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_rdir_pc   = redirect_pc & ~ADDR_W'(3);
    // A response that is actually meant for IF/ID (not dropped)
    assign w_resp_live = (r_state == S_WAIT) & imem_resp_valid & ~r_discard & ~redirect_valid;

`ifdef FETCH_HALT_EN
    logic r_halted;
    assign w_halt_word = (imem_resp_data == HALT_WORD);
    assign w_halted    = r_halted;
`else
    assign w_halt_word = 1'b0;
    assign w_halted    = 1'b0;
`endif

    assign w_skid_load  = w_resp_live & stall_i & ~w_halt_word;
    assign w_skid_drain = (r_state == S_SKID) & w_skid_valid & ~redirect_valid & ~stall_i;
    assign w_skid_clear = redirect_valid & ~w_halted;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_data  (imem_resp_data),
        .i_pc4   (w_pc_plus4),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_pc4   (w_skid_pc4)
    );

    // Fetch FSM, PC, request handshake and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_req_valid <= 1'b0;
            r_discard   <= 1'b0;
            r_id_valid  <= 1'b0;
            r_id_instr  <= BUBBLE_WORD;
            r_id_pc4    <= '0;
`ifdef FETCH_HALT_EN
            r_halted    <= 1'b0;
`endif
        end else begin
            // ID consumes the slot each unstalled cycle; refill with a bubble
            // unless a new word is loaded below
            if (!stall_i) begin
                r_id_valid <= 1'b0;
                r_id_instr <= BUBBLE_WORD;
                r_id_pc4   <= '0;
            end
            case (r_state)
                S_FETCH: begin
                    if (redirect_valid) begin
                        r_id_valid <= 1'b0;
                        r_id_instr <= BUBBLE_WORD;
                        r_id_pc4   <= '0;
                        r_pc       <= w_rdir_pc;
                    end
                    if (w_hs) begin
                        // Redirect racing the handshake: the in-flight word is stale
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                        r_discard   <= redirect_valid;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_id_valid <= 1'b0;
                        r_id_instr <= BUBBLE_WORD;
                        r_id_pc4   <= '0;
                        r_pc       <= w_rdir_pc;
                        if (imem_resp_valid) begin
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                            r_discard   <= 1'b0;
                        end else begin
                            r_discard   <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (r_discard) begin
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                            r_discard   <= 1'b0;
`ifdef FETCH_HALT_EN
                        end else if (w_halt_word) begin
                            // Halt word itself becomes a bubble (default path above)
                            r_state     <= S_HALT;
                            r_halted    <= 1'b1;
`endif
                        end else if (stall_i) begin
                            r_state     <= S_SKID;
                            r_pc        <= w_pc_plus4;
                        end else begin
                            r_id_valid  <= 1'b1;
                            r_id_instr  <= imem_resp_data;
                            r_id_pc4    <= w_pc_plus4;
                            r_pc        <= w_pc_plus4;
                            r_state     <= S_FETCH;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                S_SKID: begin
                    if (redirect_valid) begin
                        r_id_valid  <= 1'b0;
                        r_id_instr  <= BUBBLE_WORD;
                        r_id_pc4    <= '0;
                        r_pc        <= w_rdir_pc;
                        r_state     <= S_FETCH;
                        r_req_valid <= 1'b1;
                    end else if (!stall_i) begin
                        r_id_valid  <= 1'b1;
                        r_id_instr  <= w_skid_data;
                        r_id_pc4    <= w_skid_pc4;
                        r_state     <= S_FETCH;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    // HALT is absorbing until reset
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc_plus4    = r_id_pc4;
    assign id_opcode      = r_id_instr[31:26];
    assign id_funct       = r_id_instr[5:0];
    assign halted         = w_halted;

endmodule

`default_nettype wire
